// File: rtl/bram2stream_if.sv
// Purpose: BRAM read-port and AXI-Stream master signals of bram2stream, bundled.
// Latency: none, wires only.
// Backpressure: m00_axis_tready travels from the stream sink back to the block.
interface bram2stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11
);
    logic                    bram_en;
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic [DATA_WIDTH-1:0]   bram_dout;
    logic [DATA_WIDTH-1:0]   m00_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
    logic                    m00_axis_tvalid;
    logic                    m00_axis_tlast;
    logic                    m00_axis_tready;

    modport master (
        output bram_en, bram_addr,
        input  bram_dout,
        output m00_axis_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
        input  m00_axis_tready
    );

    modport slave (
        input  bram_en, bram_addr,
        output bram_dout,
        input  m00_axis_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
        output m00_axis_tready
    );
endinterface

// File: rtl/bram2stream.sv
// Purpose: replay one FRAME_LEN-word frame from a BRAM read port as an AXI-Stream master (tlast on final beat).
// Latency: start sampled at edge N, first tvalid after edge N+RD_LAT+1; one beat per cycle with tready held high.
// Backpressure: reads issue only while in-flight + FIFO words fit the RD_LAT+2 deep FIFO; loop mode via BRAM2STREAM_LOOP_EN.
module bram2stream #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11,
    parameter int FRAME_LEN  = 1056,
    parameter int RD_LAT     = 1
) (
    input  logic                 m00_axis_aclk,
    input  logic                 m00_axis_aresetn,
    input  logic                 start,
    bram2stream_if.master        bus,
    output logic                 busy,
    output logic                 done
);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int IDX_W      = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [RD_LAT-1:0]       vld_pipe_q, vld_pipe_d;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                    done_q, done_d;

    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    tvalid;
    logic                    last_beat;
    logic                    last_hs;
    logic [CNT_W-1:0]        inflight;

    // Credit check from registered counts only, plus stream-side handshake decode.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[i]);
        end
        issue     = (state_q == RUN) && (rd_idx_q < IDX_W'(FRAME_LEN))
                    && ((int'(inflight) + int'(fifo_cnt_q)) < FIFO_DEPTH);
        push      = vld_pipe_q[RD_LAT-1];
        tvalid    = (fifo_cnt_q != '0);
        pop       = tvalid && bus.m00_axis_tready;
        last_beat = (beat_cnt_q == ADDR_WIDTH'(FRAME_LEN - 1));
        last_hs   = pop && last_beat;
    end

    // Next-state: FSM, read index, beat counter, read-return pipeline and FIFO.
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        beat_cnt_d = beat_cnt_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        done_d     = last_hs;

        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        if (issue) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A start landing in the done cycle is dropped so frames never overlap.
                if (start && !done_q) begin
                    state_d    = RUN;
                    rd_idx_d   = '0;
                    beat_cnt_d = '0;
                end
            end
            RUN: begin
                if (issue && (rd_idx_q == IDX_W'(FRAME_LEN - 1))) begin
`ifdef BRAM2STREAM_LOOP_EN
                    // Wrap straight into the next frame's reads; no drain gap.
                    rd_idx_d = '0;
`else
                    state_d  = DRAIN;
`endif
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_mem_d[wr_ptr_q] = bus.bram_dout;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // State registers; reset clears the frame, the FIFO contents and every counter.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q    <= IDLE;
            rd_idx_q   <= '0;
            beat_cnt_q <= '0;
            vld_pipe_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            beat_cnt_q <= beat_cnt_d;
            vld_pipe_q <= vld_pipe_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            done_q     <= done_d;
        end
    end

    // Address is gated by the enable so it never shows an index outside the frame.
    assign bus.bram_en         = issue;
    assign bus.bram_addr       = issue ? rd_idx_q[ADDR_WIDTH-1:0] : '0;
    assign bus.m00_axis_tdata  = fifo_mem_q[rd_ptr_q];
    assign bus.m00_axis_tstrb  = '1;
    assign bus.m00_axis_tvalid = tvalid;
    assign bus.m00_axis_tlast  = last_beat && tvalid;
    assign busy                = (state_q != IDLE);
    assign done                = done_q;

    a_fifo_no_overflow: assert property (@(posedge m00_axis_aclk) disable iff (!m00_axis_aresetn)
        !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_bram2stream.sv
module tb_bram2stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic        tready = 1'b1;
    logic [2:0]  busy_v, done_v;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram2stream_if #(.DATA_WIDTH(64), .ADDR_WIDTH(11)) if_a ();
    bram2stream_if #(.DATA_WIDTH(64), .ADDR_WIDTH(11)) if_b ();
    bram2stream_if #(.DATA_WIDTH(64), .ADDR_WIDTH(11)) if_c ();

    bram2stream #(.DATA_WIDTH(64), .ADDR_WIDTH(11), .FRAME_LEN(1056), .RD_LAT(1)) u_a (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start_v[0]),
        .bus(if_a), .busy(busy_v[0]), .done(done_v[0]));
    bram2stream #(.DATA_WIDTH(64), .ADDR_WIDTH(11), .FRAME_LEN(16), .RD_LAT(2)) u_b (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start_v[1]),
        .bus(if_b), .busy(busy_v[1]), .done(done_v[1]));
    bram2stream #(.DATA_WIDTH(64), .ADDR_WIDTH(11), .FRAME_LEN(4), .RD_LAT(1)) u_c (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start_v[2]),
        .bus(if_c), .busy(busy_v[2]), .done(done_v[2]));

    assign if_a.m00_axis_tready = tready;
    assign if_b.m00_axis_tready = tready;
    assign if_c.m00_axis_tready = tready;

    // BRAM models: word at address k holds k+1.
    logic [63:0] b_stage1;
    always_ff @(posedge clk) begin
        if (if_a.bram_en) if_a.bram_dout <= 64'(if_a.bram_addr) + 64'd1;
        if (if_c.bram_en) if_c.bram_dout <= 64'(if_c.bram_addr) + 64'd1;
        if (if_b.bram_en) b_stage1 <= 64'(if_b.bram_addr) + 64'd1;
        if_b.bram_dout <= b_stage1;
    end

    // Monitor mux so one frame task can watch any instance.
    int          sel = 0;
    logic        m_vld, m_last, m_en, m_done, m_busy;
    logic [63:0] m_dat;
    logic [10:0] m_addr;
    always_comb begin
        m_vld = if_c.m00_axis_tvalid; m_last = if_c.m00_axis_tlast; m_dat = if_c.m00_axis_tdata;
        m_en = if_c.bram_en; m_addr = if_c.bram_addr; m_done = done_v[2]; m_busy = busy_v[2];
        if (sel == 0) begin
            m_vld = if_a.m00_axis_tvalid; m_last = if_a.m00_axis_tlast; m_dat = if_a.m00_axis_tdata;
            m_en = if_a.bram_en; m_addr = if_a.bram_addr; m_done = done_v[0]; m_busy = busy_v[0];
        end else if (sel == 1) begin
            m_vld = if_b.m00_axis_tvalid; m_last = if_b.m00_axis_tlast; m_dat = if_b.m00_axis_tdata;
            m_en = if_b.bram_en; m_addr = if_b.bram_addr; m_done = done_v[1]; m_busy = busy_v[1];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit          start;
        bit          rdy;
        bit          vld;
        logic [63:0] dat;
        bit          chk_dat;
        bit          last;
        bit          en;
        logic [10:0] addr;
        bit          busy;
        bit          done;
    } vec_t;

    function automatic vec_t row(bit st, bit rd, bit vl, int dt, bit cd, bit ls,
                                 bit en, int ad, bit bs, bit dn);
        vec_t r;
        r.start = st; r.rdy = rd; r.vld = vl; r.dat = 64'(dt); r.chk_dat = cd;
        r.last = ls; r.en = en; r.addr = 11'(ad); r.busy = bs; r.done = dn;
        return r;
    endfunction

    // One frame on instance s; abort_beat >= 0 resets the design after that beat is accepted.
    task automatic frame(input int s, input int flen, input int rdlat, input bit rnd, input int abort_beat);
        int exp_v, first_v, hs_edge, done_cyc, n0, seq_bad, last_bad, addr_bad;
        bit got_done, aborted;
        sel = s;
        exp_v = 1; first_v = -1; hs_edge = -1; done_cyc = -100;
        seq_bad = 0; last_bad = 0; addr_bad = 0; got_done = 0; aborted = 0;
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        n0 = cyc + 1;
        for (int k = 0; k < flen * 8 + 100 && !got_done && !aborted; k++) begin
            @(negedge clk);
            if (first_v < 0 && m_vld) first_v = cyc - n0;
            if (m_en && m_addr >= 11'(flen)) addr_bad++;
            if (m_done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            if (m_vld && tready) begin
                if (m_dat != 64'(exp_v)) seq_bad++;
                if (m_last != (exp_v == flen)) last_bad++;
                if (exp_v == flen) hs_edge = cyc + 1;
                if (exp_v == abort_beat + 1) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_tvalid", m_vld, 0);
                    check("rst_tlast", m_last, 0);
                    check("rst_tdata", m_dat, 0);
                    check("rst_bram_en", m_en, 0);
                    check("rst_bram_addr", m_addr, 0);
                    check("rst_busy", m_busy, 0);
                    check("rst_done", m_done, 0);
                    @(negedge clk); @(negedge clk);
                    rst_n = 1'b1;
                    aborted = 1;
                end
                exp_v++;
            end
            @(posedge clk); #1;
            start_v[s] = 1'b0;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        tready = 1'b1;
        if (!aborted) begin
            check($sformatf("f%0d_done_seen", s), got_done, 1);
            check($sformatf("f%0d_beats", s), exp_v - 1, flen);
            check($sformatf("f%0d_seq_errs", s), seq_bad, 0);
            check($sformatf("f%0d_tlast_errs", s), last_bad, 0);
            check($sformatf("f%0d_addr_range", s), addr_bad, 0);
            check($sformatf("f%0d_first_vld", s), first_v, rdlat + 1);
            check($sformatf("f%0d_done_after_last", s), done_cyc, hs_edge);
            if (!rnd) check($sformatf("f%0d_frame_cycles", s), done_cyc - (n0 - 1), flen + rdlat + 2);
            check($sformatf("f%0d_done_one_cycle", s), m_done, 0);
            check($sformatf("f%0d_busy_low", s), m_busy, 0);
        end
    endtask

    vec_t tbl [13];

    initial begin
        // start, rdy | vld, dat, chk_dat, last, en, addr, busy, done   (FRAME_LEN=4, RD_LAT=1)
        tbl[0]  = row(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = row(0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = row(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
        tbl[3]  = row(0, 0, 1, 1, 1, 0, 1, 2, 1, 0);
        tbl[4]  = row(0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
        tbl[5]  = row(0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
        tbl[6]  = row(0, 1, 1, 1, 1, 0, 0, 0, 1, 0);
        tbl[7]  = row(0, 1, 1, 2, 1, 0, 1, 3, 1, 0);
        tbl[8]  = row(0, 1, 1, 3, 1, 0, 0, 0, 1, 0);
        tbl[9]  = row(1, 1, 1, 4, 1, 1, 0, 0, 1, 0);
        tbl[10] = row(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[11] = row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = row(0, 1, 0, 0, 0, 0, 1, 0, 1, 0);

        repeat (3) @(negedge clk);
        check("reset_tvalid", if_a.m00_axis_tvalid, 0);
        check("reset_tlast", if_a.m00_axis_tlast, 0);
        check("reset_tdata", if_a.m00_axis_tdata, 0);
        check("reset_bram_en", if_a.bram_en, 0);
        check("reset_busy", busy_v[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tstrb_ones", if_a.m00_axis_tstrb, 8'hff);

`ifdef BRAM2STREAM_LOOP_EN
        begin
            int seen, gaps;
            sel = 2; seen = 0; gaps = 0;
            @(posedge clk); #1 start_v[2] = 1'b1;
            @(posedge clk); #1 start_v[2] = 1'b0;
            for (int k = 0; k < 40 && seen < 12; k++) begin
                @(negedge clk);
                if (seen > 0 && !m_vld) gaps++;
                if (m_vld) begin
                    check($sformatf("loop_dat%0d", seen), m_dat, (seen % 4) + 1);
                    check($sformatf("loop_last%0d", seen), m_last, (seen % 4) == 3);
                    check($sformatf("loop_done%0d", seen), m_done, (seen % 4 == 0) && seen > 0);
                    check($sformatf("loop_busy%0d", seen), m_busy, 1);
                    seen++;
                end
            end
            check("loop_beats", seen, 12);
            check("loop_gaps", gaps, 0);
        end
`else
        sel = 2;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            start_v[2] = tbl[i].start;
            tready     = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d_vld", i), if_c.m00_axis_tvalid, tbl[i].vld);
            if (tbl[i].chk_dat) check($sformatf("row%0d_dat", i), if_c.m00_axis_tdata, tbl[i].dat);
            check($sformatf("row%0d_last", i), if_c.m00_axis_tlast, tbl[i].last);
            check($sformatf("row%0d_en", i), if_c.bram_en, tbl[i].en);
            check($sformatf("row%0d_addr", i), if_c.bram_addr, tbl[i].addr);
            check($sformatf("row%0d_busy", i), busy_v[2], tbl[i].busy);
            check($sformatf("row%0d_done", i), done_v[2], tbl[i].done);
        end
        begin
            bit seen_done;
            int beats;
            seen_done = 0; beats = 0;
            for (int k = 0; k < 100 && !seen_done; k++) begin
                @(negedge clk);
                if (if_c.m00_axis_tvalid && tready) begin
                    beats++;
                    check($sformatf("c2_dat%0d", beats), if_c.m00_axis_tdata, beats);
                end
                if (done_v[2]) seen_done = 1;
            end
            check("c2_done_seen", seen_done, 1);
            check("c2_beats", beats, 4);
        end

        frame(0, 1056, 1, 0, -1);
        frame(0, 1056, 1, 1, -1);
        frame(0, 1056, 1, 0, 500);
        frame(0, 1056, 1, 0, -1);
        frame(1, 16, 2, 0, -1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
